// File: rtl/axi_arb_pkg.sv
// Shared definitions for the two-master AXI4 RAM arbiter: FSM encodings and
// the grant-index width used by both the read and write sides.
package axi_arb_pkg;

    localparam int GNT_W = 1;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } r_state_t;

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright; on contention the
// master that did not win last time is chosen. Purely combinational.
module axi_rr_arb2 import axi_arb_pkg::*; (
    input  logic [1:0]       req,
    input  logic [GNT_W-1:0] last_gnt,
    output logic [GNT_W-1:0] gnt
);

    always_comb begin
        if (req == 2'b11) begin
            gnt = ~last_gnt;
        end else begin
            gnt = req[1];
        end
    end

endmodule

// File: rtl/axi_ram_arb2.sv
// Shares one AXI4 RAM slave between two masters. Read and write sides each run
// an independent FSM that holds its grant for a whole transaction.
module axi_ram_arb2 import axi_arb_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH/8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // master 0
    input  logic [ID_WIDTH-1:0]   s0_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s0_axi_awaddr,
    input  logic [7:0]            s0_axi_awlen,
    input  logic [2:0]            s0_axi_awsize,
    input  logic [1:0]            s0_axi_awburst,
    input  logic                  s0_axi_awlock,
    input  logic [3:0]            s0_axi_awcache,
    input  logic [2:0]            s0_axi_awprot,
    input  logic                  s0_axi_awvalid,
    output logic                  s0_axi_awready,
    input  logic [DATA_WIDTH-1:0] s0_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s0_axi_wstrb,
    input  logic                  s0_axi_wlast,
    input  logic                  s0_axi_wvalid,
    output logic                  s0_axi_wready,
    output logic [ID_WIDTH-1:0]   s0_axi_bid,
    output logic [1:0]            s0_axi_bresp,
    output logic                  s0_axi_bvalid,
    input  logic                  s0_axi_bready,
    input  logic [ID_WIDTH-1:0]   s0_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
    input  logic [7:0]            s0_axi_arlen,
    input  logic [2:0]            s0_axi_arsize,
    input  logic [1:0]            s0_axi_arburst,
    input  logic                  s0_axi_arlock,
    input  logic [3:0]            s0_axi_arcache,
    input  logic [2:0]            s0_axi_arprot,
    input  logic                  s0_axi_arvalid,
    output logic                  s0_axi_arready,
    output logic [ID_WIDTH-1:0]   s0_axi_rid,
    output logic [DATA_WIDTH-1:0] s0_axi_rdata,
    output logic [1:0]            s0_axi_rresp,
    output logic                  s0_axi_rlast,
    output logic                  s0_axi_rvalid,
    input  logic                  s0_axi_rready,
    // master 1
    input  logic [ID_WIDTH-1:0]   s1_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s1_axi_awaddr,
    input  logic [7:0]            s1_axi_awlen,
    input  logic [2:0]            s1_axi_awsize,
    input  logic [1:0]            s1_axi_awburst,
    input  logic                  s1_axi_awlock,
    input  logic [3:0]            s1_axi_awcache,
    input  logic [2:0]            s1_axi_awprot,
    input  logic                  s1_axi_awvalid,
    output logic                  s1_axi_awready,
    input  logic [DATA_WIDTH-1:0] s1_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s1_axi_wstrb,
    input  logic                  s1_axi_wlast,
    input  logic                  s1_axi_wvalid,
    output logic                  s1_axi_wready,
    output logic [ID_WIDTH-1:0]   s1_axi_bid,
    output logic [1:0]            s1_axi_bresp,
    output logic                  s1_axi_bvalid,
    input  logic                  s1_axi_bready,
    input  logic [ID_WIDTH-1:0]   s1_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
    input  logic [7:0]            s1_axi_arlen,
    input  logic [2:0]            s1_axi_arsize,
    input  logic [1:0]            s1_axi_arburst,
    input  logic                  s1_axi_arlock,
    input  logic [3:0]            s1_axi_arcache,
    input  logic [2:0]            s1_axi_arprot,
    input  logic                  s1_axi_arvalid,
    output logic                  s1_axi_arready,
    output logic [ID_WIDTH-1:0]   s1_axi_rid,
    output logic [DATA_WIDTH-1:0] s1_axi_rdata,
    output logic [1:0]            s1_axi_rresp,
    output logic                  s1_axi_rlast,
    output logic                  s1_axi_rvalid,
    input  logic                  s1_axi_rready,
    // shared RAM slave
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    // state observation
    output logic [1:0]            o_dbg_wstate,
    output logic [1:0]            o_dbg_rstate
);

    // Handshakes are standard AXI: a beat transfers on a rising edge where
    // valid and ready are both high; valid never waits on ready.
    w_state_t         r_wstate, w_wstate_nxt;
    r_state_t         r_rstate, w_rstate_nxt;
    logic [GNT_W-1:0] r_wgnt, w_wgnt_nxt, r_wlast_gnt, w_wlast_nxt, w_warb_gnt;
    logic [GNT_W-1:0] r_rgnt, w_rgnt_nxt, r_rlast_gnt, w_rlast_nxt, w_rarb_gnt;
    logic [1:0]       w_awreq, w_arreq;
    logic             w_aw_fwd, w_w_fwd, w_b_fwd, w_ar_fwd, w_r_fwd;
    logic             w_wsel, w_rsel;

    assign w_awreq  = {s1_axi_awvalid, s0_axi_awvalid};
    assign w_arreq  = {s1_axi_arvalid, s0_axi_arvalid};
    assign w_wsel   = r_wgnt[0];
    assign w_rsel   = r_rgnt[0];
    assign w_aw_fwd = (r_wstate == W_ADDR);
    assign w_w_fwd  = (r_wstate == W_DATA);
    assign w_b_fwd  = (r_wstate == W_RESP);
    assign w_ar_fwd = (r_rstate == R_ADDR);
    assign w_r_fwd  = (r_rstate == R_DATA);

    axi_rr_arb2 u_warb (.req(w_awreq), .last_gnt(r_wlast_gnt), .gnt(w_warb_gnt));
    axi_rr_arb2 u_rarb (.req(w_arreq), .last_gnt(r_rlast_gnt), .gnt(w_rarb_gnt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate    <= W_IDLE;
            r_wgnt      <= '0;
            r_wlast_gnt <= '1;
            r_rstate    <= R_IDLE;
            r_rgnt      <= '0;
            r_rlast_gnt <= '1;
        end else begin
            r_wstate    <= w_wstate_nxt;
            r_wgnt      <= w_wgnt_nxt;
            r_wlast_gnt <= w_wlast_nxt;
            r_rstate    <= w_rstate_nxt;
            r_rgnt      <= w_rgnt_nxt;
            r_rlast_gnt <= w_rlast_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_wgnt_nxt   = r_wgnt;
        w_wlast_nxt  = r_wlast_gnt;
        case (r_wstate)
            W_IDLE: if (|w_awreq) begin
                w_wstate_nxt = W_ADDR;
                w_wgnt_nxt   = w_warb_gnt;
            end
            W_ADDR: if (m_axi_awvalid && m_axi_awready) w_wstate_nxt = W_DATA;
            W_DATA: if (m_axi_wvalid && m_axi_wready && m_axi_wlast) w_wstate_nxt = W_RESP;
            W_RESP: if (m_axi_bvalid && m_axi_bready) begin
                w_wstate_nxt = W_IDLE;
                w_wlast_nxt  = r_wgnt;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rgnt_nxt   = r_rgnt;
        w_rlast_nxt  = r_rlast_gnt;
        case (r_rstate)
            R_IDLE: if (|w_arreq) begin
                w_rstate_nxt = R_ADDR;
                w_rgnt_nxt   = w_rarb_gnt;
            end
            R_ADDR: if (m_axi_arvalid && m_axi_arready) w_rstate_nxt = R_DATA;
            R_DATA: if (m_axi_rvalid && m_axi_rready && m_axi_rlast) begin
                w_rstate_nxt = R_IDLE;
                w_rlast_nxt  = r_rgnt;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Forward paths are zeroed outside their phase so idle outputs are clean.
    assign m_axi_awid    = w_aw_fwd ? (w_wsel ? s1_axi_awid    : s0_axi_awid)    : '0;
    assign m_axi_awaddr  = w_aw_fwd ? (w_wsel ? s1_axi_awaddr  : s0_axi_awaddr)  : '0;
    assign m_axi_awlen   = w_aw_fwd ? (w_wsel ? s1_axi_awlen   : s0_axi_awlen)   : '0;
    assign m_axi_awsize  = w_aw_fwd ? (w_wsel ? s1_axi_awsize  : s0_axi_awsize)  : '0;
    assign m_axi_awburst = w_aw_fwd ? (w_wsel ? s1_axi_awburst : s0_axi_awburst) : '0;
    assign m_axi_awlock  = w_aw_fwd && (w_wsel ? s1_axi_awlock  : s0_axi_awlock);
    assign m_axi_awcache = w_aw_fwd ? (w_wsel ? s1_axi_awcache : s0_axi_awcache) : '0;
    assign m_axi_awprot  = w_aw_fwd ? (w_wsel ? s1_axi_awprot  : s0_axi_awprot)  : '0;
    assign m_axi_awvalid = w_aw_fwd && (w_wsel ? s1_axi_awvalid : s0_axi_awvalid);
    assign s0_axi_awready = w_aw_fwd && !w_wsel && m_axi_awready;
    assign s1_axi_awready = w_aw_fwd &&  w_wsel && m_axi_awready;

    assign m_axi_wdata   = w_w_fwd ? (w_wsel ? s1_axi_wdata : s0_axi_wdata) : '0;
    assign m_axi_wstrb   = w_w_fwd ? (w_wsel ? s1_axi_wstrb : s0_axi_wstrb) : '0;
    assign m_axi_wlast   = w_w_fwd && (w_wsel ? s1_axi_wlast  : s0_axi_wlast);
    assign m_axi_wvalid  = w_w_fwd && (w_wsel ? s1_axi_wvalid : s0_axi_wvalid);
    assign s0_axi_wready = w_w_fwd && !w_wsel && m_axi_wready;
    assign s1_axi_wready = w_w_fwd &&  w_wsel && m_axi_wready;

    assign s0_axi_bid    = (w_b_fwd && !w_wsel) ? m_axi_bid   : '0;
    assign s0_axi_bresp  = (w_b_fwd && !w_wsel) ? m_axi_bresp : '0;
    assign s0_axi_bvalid = w_b_fwd && !w_wsel && m_axi_bvalid;
    assign s1_axi_bid    = (w_b_fwd &&  w_wsel) ? m_axi_bid   : '0;
    assign s1_axi_bresp  = (w_b_fwd &&  w_wsel) ? m_axi_bresp : '0;
    assign s1_axi_bvalid = w_b_fwd &&  w_wsel && m_axi_bvalid;
    assign m_axi_bready  = w_b_fwd && (w_wsel ? s1_axi_bready : s0_axi_bready);

    assign m_axi_arid    = w_ar_fwd ? (w_rsel ? s1_axi_arid    : s0_axi_arid)    : '0;
    assign m_axi_araddr  = w_ar_fwd ? (w_rsel ? s1_axi_araddr  : s0_axi_araddr)  : '0;
    assign m_axi_arlen   = w_ar_fwd ? (w_rsel ? s1_axi_arlen   : s0_axi_arlen)   : '0;
    assign m_axi_arsize  = w_ar_fwd ? (w_rsel ? s1_axi_arsize  : s0_axi_arsize)  : '0;
    assign m_axi_arburst = w_ar_fwd ? (w_rsel ? s1_axi_arburst : s0_axi_arburst) : '0;
    assign m_axi_arlock  = w_ar_fwd && (w_rsel ? s1_axi_arlock  : s0_axi_arlock);
    assign m_axi_arcache = w_ar_fwd ? (w_rsel ? s1_axi_arcache : s0_axi_arcache) : '0;
    assign m_axi_arprot  = w_ar_fwd ? (w_rsel ? s1_axi_arprot  : s0_axi_arprot)  : '0;
    assign m_axi_arvalid = w_ar_fwd && (w_rsel ? s1_axi_arvalid : s0_axi_arvalid);
    assign s0_axi_arready = w_ar_fwd && !w_rsel && m_axi_arready;
    assign s1_axi_arready = w_ar_fwd &&  w_rsel && m_axi_arready;

    assign s0_axi_rid    = (w_r_fwd && !w_rsel) ? m_axi_rid   : '0;
    assign s0_axi_rdata  = (w_r_fwd && !w_rsel) ? m_axi_rdata : '0;
    assign s0_axi_rresp  = (w_r_fwd && !w_rsel) ? m_axi_rresp : '0;
    assign s0_axi_rlast  = w_r_fwd && !w_rsel && m_axi_rlast;
    assign s0_axi_rvalid = w_r_fwd && !w_rsel && m_axi_rvalid;
    assign s1_axi_rid    = (w_r_fwd &&  w_rsel) ? m_axi_rid   : '0;
    assign s1_axi_rdata  = (w_r_fwd &&  w_rsel) ? m_axi_rdata : '0;
    assign s1_axi_rresp  = (w_r_fwd &&  w_rsel) ? m_axi_rresp : '0;
    assign s1_axi_rlast  = w_r_fwd &&  w_rsel && m_axi_rlast;
    assign s1_axi_rvalid = w_r_fwd &&  w_rsel && m_axi_rvalid;
    assign m_axi_rready  = w_r_fwd && (w_rsel ? s1_axi_rready : s0_axi_rready);

    assign o_dbg_wstate = r_wstate;
    assign o_dbg_rstate = r_rstate;

endmodule

// File: tb/tb_axi_ram_arb2.sv
// Directed bench for axi_ram_arb2 with a small behavioural AXI RAM slave and
// an expected-data queue for read beats.
module tb_axi_ram_arb2;
  import axi_arb_pkg::*;

  localparam int IW  = 8;
  localparam int TMO = 200;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // master-side signals, index = master number
  logic [IW-1:0] awid[2];   logic [15:0] awaddr[2]; logic [7:0] awlen[2];
  logic [2:0]    awsize[2]; logic [1:0]  awburst[2]; logic [3:0] awcache[2];
  logic [2:0]    awprot[2]; logic [1:0]  awlock, awvalid, awready;
  logic [31:0]   wdata[2];  logic [3:0]  wstrb[2];  logic [1:0] wlast, wvalid, wready;
  logic [IW-1:0] bid[2];    logic [1:0]  bresp[2];  logic [1:0] bvalid, bready;
  logic [IW-1:0] arid[2];   logic [15:0] araddr[2]; logic [7:0] arlen[2];
  logic [2:0]    arsize[2]; logic [1:0]  arburst[2]; logic [3:0] arcache[2];
  logic [2:0]    arprot[2]; logic [1:0]  arlock, arvalid, arready;
  logic [IW-1:0] rid[2];    logic [31:0] rdata[2];  logic [1:0] rresp[2];
  logic [1:0]    rlast, rvalid, rready;

  // slave-side signals
  logic [IW-1:0] m_awid, m_arid, m_bid, m_rid;
  logic [15:0]   m_awaddr, m_araddr;
  logic [7:0]    m_awlen, m_arlen;
  logic [2:0]    m_awsize, m_arsize, m_awprot, m_arprot;
  logic [1:0]    m_awburst, m_arburst, m_bresp, m_rresp;
  logic [3:0]    m_awcache, m_arcache, m_wstrb;
  logic          m_awlock, m_arlock, m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic          m_bvalid, m_bready, m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic [31:0]   m_wdata, m_rdata;
  logic [1:0]    o_dbg_wstate, o_dbg_rstate;

  axi_ram_arb2 dut (
    .clk(clk), .rst_n(rst_n),
    .s0_axi_awid(awid[0]), .s0_axi_awaddr(awaddr[0]), .s0_axi_awlen(awlen[0]),
    .s0_axi_awsize(awsize[0]), .s0_axi_awburst(awburst[0]), .s0_axi_awlock(awlock[0]),
    .s0_axi_awcache(awcache[0]), .s0_axi_awprot(awprot[0]), .s0_axi_awvalid(awvalid[0]),
    .s0_axi_awready(awready[0]), .s0_axi_wdata(wdata[0]), .s0_axi_wstrb(wstrb[0]),
    .s0_axi_wlast(wlast[0]), .s0_axi_wvalid(wvalid[0]), .s0_axi_wready(wready[0]),
    .s0_axi_bid(bid[0]), .s0_axi_bresp(bresp[0]), .s0_axi_bvalid(bvalid[0]),
    .s0_axi_bready(bready[0]), .s0_axi_arid(arid[0]), .s0_axi_araddr(araddr[0]),
    .s0_axi_arlen(arlen[0]), .s0_axi_arsize(arsize[0]), .s0_axi_arburst(arburst[0]),
    .s0_axi_arlock(arlock[0]), .s0_axi_arcache(arcache[0]), .s0_axi_arprot(arprot[0]),
    .s0_axi_arvalid(arvalid[0]), .s0_axi_arready(arready[0]), .s0_axi_rid(rid[0]),
    .s0_axi_rdata(rdata[0]), .s0_axi_rresp(rresp[0]), .s0_axi_rlast(rlast[0]),
    .s0_axi_rvalid(rvalid[0]), .s0_axi_rready(rready[0]),
    .s1_axi_awid(awid[1]), .s1_axi_awaddr(awaddr[1]), .s1_axi_awlen(awlen[1]),
    .s1_axi_awsize(awsize[1]), .s1_axi_awburst(awburst[1]), .s1_axi_awlock(awlock[1]),
    .s1_axi_awcache(awcache[1]), .s1_axi_awprot(awprot[1]), .s1_axi_awvalid(awvalid[1]),
    .s1_axi_awready(awready[1]), .s1_axi_wdata(wdata[1]), .s1_axi_wstrb(wstrb[1]),
    .s1_axi_wlast(wlast[1]), .s1_axi_wvalid(wvalid[1]), .s1_axi_wready(wready[1]),
    .s1_axi_bid(bid[1]), .s1_axi_bresp(bresp[1]), .s1_axi_bvalid(bvalid[1]),
    .s1_axi_bready(bready[1]), .s1_axi_arid(arid[1]), .s1_axi_araddr(araddr[1]),
    .s1_axi_arlen(arlen[1]), .s1_axi_arsize(arsize[1]), .s1_axi_arburst(arburst[1]),
    .s1_axi_arlock(arlock[1]), .s1_axi_arcache(arcache[1]), .s1_axi_arprot(arprot[1]),
    .s1_axi_arvalid(arvalid[1]), .s1_axi_arready(arready[1]), .s1_axi_rid(rid[1]),
    .s1_axi_rdata(rdata[1]), .s1_axi_rresp(rresp[1]), .s1_axi_rlast(rlast[1]),
    .s1_axi_rvalid(rvalid[1]), .s1_axi_rready(rready[1]),
    .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen),
    .m_axi_awsize(m_awsize), .m_axi_awburst(m_awburst), .m_axi_awlock(m_awlock),
    .m_axi_awcache(m_awcache), .m_axi_awprot(m_awprot), .m_axi_awvalid(m_awvalid),
    .m_axi_awready(m_awready), .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
    .m_axi_wlast(m_wlast), .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid),
    .m_axi_bready(m_bready), .m_axi_arid(m_arid), .m_axi_araddr(m_araddr),
    .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst),
    .m_axi_arlock(m_arlock), .m_axi_arcache(m_arcache), .m_axi_arprot(m_arprot),
    .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready), .m_axi_rid(m_rid),
    .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
    .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
    .o_dbg_wstate(o_dbg_wstate), .o_dbg_rstate(o_dbg_rstate)
  );

  // behavioural RAM slave: word addressed, INCR bursts, reset with the arbiter
  logic [31:0]   mem[64];
  logic [1:0]    sl_ws;
  logic [5:0]    sl_waddr, sl_raddr;
  logic [IW-1:0] sl_wid, sl_rid;
  logic          sl_rs;
  logic [7:0]    sl_rcnt;

  assign m_awready = (sl_ws == 2'd0);
  assign m_wready  = (sl_ws == 2'd1);
  assign m_bvalid  = (sl_ws == 2'd2);
  assign m_bid     = sl_wid;
  assign m_bresp   = 2'b00;
  assign m_arready = !sl_rs;
  assign m_rvalid  = sl_rs;
  assign m_rid     = sl_rid;
  assign m_rdata   = mem[sl_raddr];
  assign m_rlast   = (sl_rcnt == 8'd0);
  assign m_rresp   = 2'b00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_ws <= 2'd0; sl_rs <= 1'b0; sl_waddr <= '0; sl_raddr <= '0;
      sl_wid <= '0; sl_rid <= '0; sl_rcnt <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= 32'hD000_0000 + i;
    end else begin
      case (sl_ws)
        2'd0: if (m_awvalid) begin sl_waddr <= m_awaddr[7:2]; sl_wid <= m_awid; sl_ws <= 2'd1; end
        2'd1: if (m_wvalid) begin
          mem[sl_waddr] <= m_wdata;
          sl_waddr <= sl_waddr + 6'd1;
          if (m_wlast) sl_ws <= 2'd2;
        end
        2'd2: if (m_bready) sl_ws <= 2'd0;
        default: sl_ws <= 2'd0;
      endcase
      if (!sl_rs) begin
        if (m_arvalid) begin
          sl_raddr <= m_araddr[7:2]; sl_rid <= m_arid; sl_rcnt <= m_arlen; sl_rs <= 1'b1;
        end
      end else if (m_rready) begin
        sl_raddr <= sl_raddr + 6'd1;
        if (sl_rcnt == 8'd0) sl_rs <= 1'b0;
        else sl_rcnt <= sl_rcnt - 8'd1;
      end
    end
  end

  // scoreboard and observation
  logic [31:0] exp_q[$];
  int n_tests = 0, n_fail = 0;
  int aw_cyc[2], b_cyc[2], ar_cyc[2], rl_cyc[2], b_count[2];
  int aw_order[$];
  int rv0_cnt = 0, overlap = 0;

  always @(negedge clk) begin
    if (awready[0]) aw_order.push_back(0);
    if (awready[1]) aw_order.push_back(1);
    if (rvalid[0]) rv0_cnt++;
    if (o_dbg_wstate != 2'd0 && o_dbg_rstate != 2'd0) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic aw_phase(input int m, input logic [IW-1:0] id, input logic [15:0] addr,
                          input logic [7:0] len);
    int n = 0;
    awid[m] = id; awaddr[m] = addr; awlen[m] = len; awvalid[m] = 1'b1;
    do begin @(negedge clk); n++; end while (!awready[m] && n < TMO);
    check("aw_wait", n < TMO, 1);
    check("aw_addr_fwd", m_awaddr, addr);
    aw_cyc[m] = cyc;
    @(posedge clk); #1 awvalid[m] = 1'b0;
  endtask

  task automatic w_beat(input int m, input logic [31:0] data, input logic last);
    int n = 0;
    wdata[m] = data; wlast[m] = last; wvalid[m] = 1'b1;
    do begin @(negedge clk); n++; end while (!wready[m] && n < TMO);
    check("w_wait", n < TMO, 1);
    check("w_data_fwd", m_wdata, data);
    @(posedge clk); #1 wvalid[m] = 1'b0; wlast[m] = 1'b0;
  endtask

  task automatic b_phase(input int m, input logic [IW-1:0] id, input int dly);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bvalid[m] && n < TMO);
    check("b_wait", n < TMO, 1);
    for (int i = 0; i < dly; i++) begin
      check("b_hold_state", o_dbg_wstate, W_RESP);
      check("b_hold_awrdy", awready, 2'b00);
      @(negedge clk);
    end
    bready[m] = 1'b1;
    check("b_id", bid[m], id);
    check("b_resp", bresp[m], 2'b00);
    b_cyc[m] = cyc;
    b_count[m]++;
    @(posedge clk); #1 bready[m] = 1'b0;
  endtask

  task automatic axi_write(input int m, input logic [IW-1:0] id, input logic [15:0] addr,
                           input logic [7:0] len, input logic [31:0] base, input int dly);
    aw_phase(m, id, addr, len);
    for (int i = 0; i <= int'(len); i++) w_beat(m, base + i, i == int'(len));
    b_phase(m, id, dly);
  endtask

  task automatic axi_read(input int m, input logic [IW-1:0] id, input logic [15:0] addr,
                          input logic [7:0] len, input bit chk_data, input bit toggle);
    int n = 0;
    int beat = 0;
    arid[m] = id; araddr[m] = addr; arlen[m] = len; arvalid[m] = 1'b1;
    do begin @(negedge clk); n++; end while (!arready[m] && n < TMO);
    check("ar_wait", n < TMO, 1);
    check("ar_addr_fwd", m_araddr, addr);
    ar_cyc[m] = cyc;
    @(posedge clk); #1 arvalid[m] = 1'b0;
    rready[m] = 1'b0;
    n = 0;
    while (beat <= int'(len) && n < TMO) begin
      @(negedge clk); n++;
      rready[m] = toggle ? ~rready[m] : 1'b1;
      if (rvalid[m] && rready[m]) begin
        if (chk_data) check("r_data", rdata[m], exp_q.pop_front());
        check("r_id", rid[m], id);
        check("r_last", rlast[m], beat == int'(len));
        if (beat == int'(len)) rl_cyc[m] = cyc;
        beat++;
      end
    end
    check("r_beats", beat, int'(len) + 1);
    @(posedge clk); #1 rready[m] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int rel_cyc;
    int snap;
    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      awid[m] = '0; awaddr[m] = '0; awlen[m] = '0; awsize[m] = 3'd2; awburst[m] = 2'd1;
      awcache[m] = '0; awprot[m] = '0; wdata[m] = '0; wstrb[m] = 4'hF;
      arid[m] = '0; araddr[m] = '0; arlen[m] = '0; arsize[m] = 3'd2; arburst[m] = 2'd1;
      arcache[m] = '0; arprot[m] = '0;
      b_count[m] = 0;
    end
    awlock = '0; awvalid = '0; wlast = '0; wvalid = '0; bready = '0;
    arlock = '0; rready = '0;
    arvalid = 2'b11;

    // reset with both masters requesting reads
    repeat (3) @(negedge clk);
    check("rst_arready", arready, 2'b00);
    check("rst_s_ready", {awready, wready, bvalid, rvalid}, 8'h00);
    check("rst_m_valid", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 5'b0);
    check("rst_state", {o_dbg_wstate, o_dbg_rstate}, 4'h0);
    rst_n = 1'b1;
    rel_cyc = cyc;
    exp_q.push_back(32'hD000_0000); exp_q.push_back(32'hD000_0001);
    exp_q.push_back(32'hD000_0008);
    fork
      axi_read(0, 8'h11, 16'h0000, 8'd1, 1'b1, 1'b0);
      axi_read(1, 8'h22, 16'h0020, 8'd0, 1'b1, 1'b0);
    join
    check("ar0_grant_latency", ar_cyc[0] - rel_cyc, 1);
    check("ar1_after_rlast", ar_cyc[1] - rl_cyc[0], 2);

    // concurrent write (m0) and read (m1), then readback
    overlap = 0;
    fork
      axi_write(0, 8'h05, 16'h0010, 8'd3, 32'h0000_00A0, 0);
      axi_read(1, 8'h06, 16'h0010, 8'd3, 1'b0, 1'b0);
    join
    check("rw_concurrent", overlap != 0, 1);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_00A0 + i);
    axi_read(0, 8'h07, 16'h0010, 8'd3, 1'b1, 1'b0);

    // m1 8-beat read with rready toggling; m0 must never see rvalid
    for (int i = 0; i < 8; i++) exp_q.push_back(32'hD000_0010 + i);
    snap = rv0_cnt;
    axi_read(1, 8'h33, 16'h0040, 8'd7, 1'b1, 1'b1);
    check("m0_rvalid_quiet", rv0_cnt - snap, 0);

    // reset in the middle of a write burst
    aw_phase(0, 8'h44, 16'h0080, 8'd3);
    w_beat(0, 32'h0000_00B0, 1'b0);
    w_beat(0, 32'h0000_00B1, 1'b0);
    wdata[0] = 32'h0000_00B2; wvalid[0] = 1'b1;
    @(negedge clk);
    check("mid_pre_state", o_dbg_wstate, W_DATA);
    #2 rst_n = 1'b0;
    #1;
    check("mid_s_ready", {awready, wready, arready, bvalid, rvalid}, 10'h000);
    check("mid_m_valid", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 5'b0);
    check("mid_state", {o_dbg_wstate, o_dbg_rstate}, 4'h0);
    wvalid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    axi_write(1, 8'h55, 16'h0080, 8'd1, 32'h0000_00C0, 0);
    exp_q.push_back(32'h0000_00C0); exp_q.push_back(32'h0000_00C1);
    axi_read(1, 8'h56, 16'h0080, 8'd1, 1'b1, 1'b0);

    // 5 back-to-back single-beat writes from each master
    aw_order.delete();
    b_count[0] = 0; b_count[1] = 0;
    fork
      for (int i = 0; i < 5; i++) axi_write(0, 8'h61, 16'h00C0 + 16'(4*i), 8'd0, 32'h100 + i, 0);
      for (int i = 0; i < 5; i++) axi_write(1, 8'h62, 16'h00E0 + 16'(4*i), 8'd0, 32'h200 + i, 0);
    join
    check("alt_b_count0", b_count[0], 5);
    check("alt_b_count1", b_count[1], 5);
    check("alt_grants", aw_order.size(), 10);
    for (int i = 0; i < aw_order.size(); i++) check("alt_order", aw_order[i], i % 2);

    // m1 holds bready low; m0's AW waits for B handshake plus one idle cycle
    fork
      axi_write(1, 8'h77, 16'h0004, 8'd0, 32'h0000_00E0, 4);
      begin
        repeat (3) @(negedge clk);
        axi_write(0, 8'h78, 16'h0008, 8'd0, 32'h0000_00E1, 0);
      end
    join
    check("b_to_aw_gap", aw_cyc[0] - b_cyc[1], 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_ram_arb2.md
# axi_ram_arb2

Two-master AXI4 arbiter that shares one `axi_ram_per` slave between two requesters, such as the VexRiscv instruction and data buses.
- Read and write channels are arbitrated independently, each with its own round-robin arbiter.
- A grant is held for a whole transaction: from address acceptance to the last R beat (read side), or to the B handshake (write side).
- Because each side has at most one transaction in flight, responses are routed by the registered grant and IDs pass through unchanged.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data bus width in bits.
- `ADDR_WIDTH`, 16: address width in bits.
- `STRB_WIDTH`, `DATA_WIDTH/8`: write-strobe width.
- `ID_WIDTH`, 8: ID width, the same on all ports.

Ports:
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `s{0,1}_axi_aw{id,addr,len,size,burst,lock,cache,prot,valid}`  in  AXI4 widths  write address from master 0/1.
- `s{0,1}_axi_awready`  out  1  write address ready to master 0/1.
- `s{0,1}_axi_w{data,strb,last,valid}`  in  AXI4 widths  write data from master 0/1.
- `s{0,1}_axi_wready`  out  1  write data ready.
- `s{0,1}_axi_b{id,resp,valid}`  out  `ID_WIDTH`/2/1  write response.
- `s{0,1}_axi_bready`  in  1  write response ready.
- `s{0,1}_axi_ar{id,addr,len,size,burst,lock,cache,prot,valid}`  in  AXI4 widths  read address.
- `s{0,1}_axi_arready`  out  1  read address ready.
- `s{0,1}_axi_r{id,data,resp,last,valid}`  out  AXI4 widths  read data.
- `s{0,1}_axi_rready`  in  1  read data ready.
- `m_axi_*`  mirrored directions  AXI4 widths  the full AXI4 interface to the shared RAM slave.

## Operation
Write arbiter states:
- `W_IDLE`:
  - If any `sN_axi_awvalid` is high, latch the winner into `wgnt` and go to `W_ADDR`.
  - Winner: a single requester wins outright; if both request, the master not granted last time (`wlast_gnt`) wins.
- `W_ADDR`:
  - All AW fields of master `wgnt` are muxed combinationally to `m_axi_aw*`.
  - `s[wgnt]_axi_awready = m_axi_awready`.
  - On the AW handshake, go to `W_DATA`.
- `W_DATA`:
  - W is muxed from master `wgnt`; `s[wgnt]_axi_wready = m_axi_wready`.
  - On a W handshake with `wlast` high, go to `W_RESP`.
- `W_RESP`:
  - `m_axi_b*` is routed to master `wgnt`; `m_axi_bready = s[wgnt]_axi_bready`.
  - On the B handshake, update `wlast_gnt <= wgnt` and go to `W_IDLE`.

Read arbiter states:
- `R_IDLE`: same selection rule as `W_IDLE`, using `rgnt` and `rlast_gnt`; go to `R_ADDR`.
- `R_ADDR`: AR muxed from master `rgnt`; on the AR handshake, go to `R_DATA`.
- `R_DATA`:
  - R is routed to master `rgnt`.
  - On an R handshake with `rlast` high, update `rlast_gnt` and go to `R_IDLE`.

Rules that apply in every state:
- The non-granted master always sees ready=0 and valid=0.
- `m_axi_*valid` is 0 in any state that does not forward that channel.
- Write data offered before `W_DATA` is stalled (`wready`=0).

Boundary conditions:
- `awlen`/`arlen` = 0: the single beat carries `last` high and completes `W_DATA`/`R_DATA` in one handshake.
- Both masters requesting after reset: master 0 wins, because `*last_gnt` resets to 1.
- A request withdrawn in `*_ADDR` is an AXI violation and is not required to be handled.
- A master that is denied keeps its valid high; it is served after the current transaction completes.
- Reads and writes from the same or different masters proceed concurrently.
- `rst_n` low mid-burst:
  - Immediately forces both FSMs to `*_IDLE` and `*last_gnt` to 1.
  - All ready/valid outputs go to 0.
  - The RAM must be reset in the same event.

## Timing
- Reset values:
  - All `sN_axi_{awready,wready,arready,bvalid,rvalid}` = 0.
  - All `m_axi_{awvalid,wvalid,arvalid,bready,rready}` = 0.
  - All routed data/ID outputs are don't-care and are driven to 0.
- Grant latency: a request seen in `*_IDLE` at edge n gives the grant at edge n+1; `m_axi_awvalid`/`m_axi_arvalid` are high during cycle n+1.
- One idle cycle after each completing handshake before the next grant (the return to `*_IDLE`).
- The data paths (AW/W/B/AR/R) add zero latency: they are pure muxes controlled by registered state.
- The only registers are the state, `*gnt` and `*last_gnt`.

## Structure
- Shared package `axi_arb_pkg` holds:
  - the write FSM encoding: `W_IDLE`=0, `W_ADDR`=1, `W_DATA`=2, `W_RESP`=3;
  - the read FSM encoding: `R_IDLE`=0, `R_ADDR`=1, `R_DATA`=2;
  - the grant-index width (1).
- Sub-module `axi_rr_arb2`:
  - 2-way round-robin arbiter with inputs `req[1:0]` and `last_gnt`, output `gnt`;
  - instantiated once for the write side and once for the read side.

## Test plan
- Reset with both masters requesting AR → no ready asserted while `rst_n`=0. After release, master 0 gets `arready`, and master 1 gets the grant after master 0's `rlast` handshake plus 1 idle cycle.
- Master 0 write, `awaddr`=0x10, `awlen`=3, data 0xA0..0xA3, and simultaneously master 1 read of 0x10, `arlen`=3 → the read proceeds concurrently. RAM readback after B shows 0xA0..0xA3.
- Both masters issue 5 back-to-back single-beat writes → grants alternate 0,1,0,1…; each master receives exactly 5 B responses carrying its own `awid`.
- Master 1 read, `arlen`=7, with `rready` toggling every cycle → 8 beats to master 1 only, `rlast` on beat 8; master 0 `rvalid` stays 0 throughout.
- `rst_n` asserted in `W_DATA` after 2 of 4 beats → all valids/readies drop to 0 asynchronously; after release, a fresh write from master 1 completes normally.
- `awlen`=0 write from master 1 with `bready` held low for 4 cycles → arbiter stays in `W_RESP`; master 0's AW is held off until the B handshake plus 1 cycle.
